// File: rtl/pulp_boot_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pulp_boot_sequencer: staged PULPino bring-up after MMCM lock, soft restart |
// | button, fetch park switch, status LEDs.                 Revision: 1.0      |
// +----------------------------------------------------------------------------+
module pulp_boot_sequencer #(
   parameter int SETTLE_CYCLES    = 1024,
   parameter int FETCH_DELAY      = 256,
   parameter int RESTART_CYCLES   = 64,
   parameter int DEBOUNCE_CYCLES  = 500000,
   parameter int HEARTBEAT_CYCLES = 25000000,
   parameter int CNT_W            = 32
) (
   input  logic       pulp_clk,
   input  logic       pulp_rstn,
   input  logic       mmcm_locked_i,
   input  logic       restart_btn_i,
   input  logic       hold_fetch_i,
   output logic       core_rstn_o,
   output logic       fetch_enable_o,
   output logic [2:0] state_o,
   output logic [3:0] led_o
);

   typedef enum logic [2:0] {
      ST_LOCK    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_RELEASE = 3'd2,
      ST_RUN     = 3'd3,
      ST_HOLD    = 3'd4,
      ST_RESTART = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] C_SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_FETCH_LAST   = CNT_W'(FETCH_DELAY - 1);
   localparam logic [CNT_W-1:0] C_RESTART_LAST = CNT_W'(RESTART_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_DB_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_HB_LAST      = CNT_W'(HEARTBEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_ONE          = CNT_W'(1);

   logic             r_lock_meta, r_lock_s;
   logic             r_btn_meta, r_btn_s;
   logic             r_hold_meta, r_hold_s;
   logic [CNT_W-1:0] r_db_cnt;
   logic             r_btn_db, r_btn_db_d;
   logic [CNT_W-1:0] r_hb_cnt;
   logic             r_hb;
   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             w_restart_p;
   logic             w_core_active;
   logic             w_led0;

   always_ff @(posedge pulp_clk or negedge pulp_rstn) begin
      if (!pulp_rstn) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
         r_btn_meta  <= 1'b0;
         r_btn_s     <= 1'b0;
         r_hold_meta <= 1'b0;
         r_hold_s    <= 1'b0;
      end else begin
         r_lock_meta <= mmcm_locked_i;
         r_lock_s    <= r_lock_meta;
         r_btn_meta  <= restart_btn_i;
         r_btn_s     <= r_btn_meta;
         r_hold_meta <= hold_fetch_i;
         r_hold_s    <= r_hold_meta;
      end
   end

   // A new button level is accepted only after it has differed for DEBOUNCE_CYCLES in a row.
   always_ff @(posedge pulp_clk or negedge pulp_rstn) begin
      if (!pulp_rstn) begin
         r_db_cnt   <= '0;
         r_btn_db   <= 1'b0;
         r_btn_db_d <= 1'b0;
      end else begin
         r_btn_db_d <= r_btn_db;
         if (r_btn_s == r_btn_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == C_DB_LAST) begin
            r_db_cnt <= '0;
            r_btn_db <= r_btn_s;
         end else begin
            r_db_cnt <= r_db_cnt + C_ONE;
         end
      end
   end

   assign w_restart_p = r_btn_db & ~r_btn_db_d;

   always_ff @(posedge pulp_clk or negedge pulp_rstn) begin
      if (!pulp_rstn) begin
         r_hb_cnt <= '0;
         r_hb     <= 1'b0;
      end else if (r_hb_cnt == C_HB_LAST) begin
         r_hb_cnt <= '0;
         r_hb     <= ~r_hb;
      end else begin
         r_hb_cnt <= r_hb_cnt + C_ONE;
      end
   end

   always_comb begin
      w_next = r_state;
      if (r_state != ST_LOCK && !r_lock_s) begin
         w_next = ST_LOCK;
      end else if (w_restart_p &&
                   (r_state == ST_RELEASE || r_state == ST_RUN || r_state == ST_HOLD)) begin
         w_next = ST_RESTART;
      end else begin
         case (r_state)
            ST_LOCK:    if (r_lock_s) w_next = ST_SETTLE;
            ST_SETTLE:  if (r_cnt == C_SETTLE_LAST) w_next = ST_RELEASE;
            ST_RELEASE: if (r_cnt == C_FETCH_LAST) w_next = r_hold_s ? ST_HOLD : ST_RUN;
            ST_RUN:     if (r_hold_s) w_next = ST_HOLD;
            ST_HOLD:    if (!r_hold_s) w_next = ST_RUN;
            ST_RESTART: if (r_cnt == C_RESTART_LAST) w_next = ST_SETTLE;
            default:    w_next = ST_LOCK;
         endcase
      end
   end

   assign w_core_active = (w_next == ST_RELEASE) || (w_next == ST_RUN) || (w_next == ST_HOLD);

   // Outputs decode next state so they switch on the same edge as the state register.
   always_ff @(posedge pulp_clk or negedge pulp_rstn) begin
      if (!pulp_rstn) begin
         r_state        <= ST_LOCK;
         r_cnt          <= '0;
         core_rstn_o    <= 1'b0;
         fetch_enable_o <= 1'b0;
      end else begin
         r_state        <= w_next;
         core_rstn_o    <= w_core_active;
         fetch_enable_o <= (w_next == ST_RUN);
         if (w_next != r_state) begin
            r_cnt <= '0;
         end else if (r_state == ST_SETTLE || r_state == ST_RELEASE || r_state == ST_RESTART) begin
            r_cnt <= r_cnt + C_ONE;
         end
      end
   end

   assign w_led0  = (r_state == ST_RUN) ? r_hb : (r_state == ST_HOLD);
   assign state_o = r_state;
   assign led_o   = {r_hold_s, fetch_enable_o, r_lock_s, w_led0};

endmodule
`default_nettype wire

// File: tb/tb_pulp_boot_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pulp_boot_sequencer: randomized directed bench with a countdown-based   |
// | reference model of the boot sequence.                   Revision: 1.0      |
// +----------------------------------------------------------------------------+
module tb_pulp_boot_sequencer;

   localparam int SETTLE = 16;
   localparam int FETCH  = 8;
   localparam int RESTRT = 8;
   localparam int DEB    = 4;
   localparam int HB     = 10;

   logic       pulp_clk = 1'b0;
   logic       pulp_rstn = 1'b1;
   logic       mmcm_locked_i = 1'b0;
   logic       restart_btn_i = 1'b0;
   logic       hold_fetch_i = 1'b0;
   logic       core_rstn_o;
   logic       fetch_enable_o;
   logic [2:0] state_o;
   logic [3:0] led_o;

   int n_cmp = 0;
   int n_fail = 0;
   string phase = "reset";

   // model state: 0 LOCK 1 SETTLE 2 RELEASE 3 RUN 4 HOLD 5 RESTART
   int m_state, m_left, m_edges, m_run;
   bit m_lock1, m_lock_s, m_btn1, m_btn_s, m_hold1, m_hold_s, m_db, m_pulse;

   pulp_boot_sequencer #(
      .SETTLE_CYCLES(SETTLE), .FETCH_DELAY(FETCH), .RESTART_CYCLES(RESTRT),
      .DEBOUNCE_CYCLES(DEB), .HEARTBEAT_CYCLES(HB), .CNT_W(32)
   ) dut (
      .pulp_clk(pulp_clk), .pulp_rstn(pulp_rstn), .mmcm_locked_i(mmcm_locked_i),
      .restart_btn_i(restart_btn_i), .hold_fetch_i(hold_fetch_i),
      .core_rstn_o(core_rstn_o), .fetch_enable_o(fetch_enable_o),
      .state_o(state_o), .led_o(led_o)
   );

   always #5 pulp_clk = ~pulp_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic int duration(input int st);
      case (st)
         1:       return SETTLE;
         2:       return FETCH;
         5:       return RESTRT;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_state = 0; m_left = 0; m_edges = 0; m_run = 0;
      m_lock1 = 0; m_lock_s = 0; m_btn1 = 0; m_btn_s = 0;
      m_hold1 = 0; m_hold_s = 0; m_db = 0; m_pulse = 0;
   endtask

   task automatic apply_reset();
      pulp_rstn = 1'b0;
      #1;
      check({phase, " async_reset"}, {core_rstn_o, fetch_enable_o, state_o, led_o}, 9'd0);
      model_reset();
      #1;
      pulp_rstn = 1'b1;
   endtask

   task automatic tick1();
      int  ns, nl, nrun;
      bit  ndb, np, lk, bt, hd, led0, exp_rstn, exp_fetch;
      lk = mmcm_locked_i; bt = restart_btn_i; hd = hold_fetch_i;
      ns = m_state; nl = m_left;
      if (m_state != 0 && !m_lock_s) ns = 0;
      else if (m_pulse && (m_state == 2 || m_state == 3 || m_state == 4)) ns = 5;
      else begin
         case (m_state)
            0: if (m_lock_s) ns = 1;
            1, 2, 5: begin
               nl = m_left - 1;
               if (nl == 0) ns = (m_state == 1) ? 2 : (m_state == 5) ? 1 : (m_hold_s ? 4 : 3);
            end
            3: if (m_hold_s) ns = 4;
            4: if (!m_hold_s) ns = 3;
            default: ns = 0;
         endcase
      end
      if (ns != m_state) nl = duration(ns);
      ndb = m_db; np = 0; nrun = 0;
      if (m_btn_s != m_db) begin
         nrun = m_run + 1;
         if (nrun == DEB) begin
            ndb = m_btn_s; nrun = 0; np = m_btn_s;
         end
      end
      @(posedge pulp_clk);
      #1;
      m_state = ns; m_left = nl; m_db = ndb; m_pulse = np; m_run = nrun;
      m_lock_s = m_lock1; m_lock1 = lk;
      m_btn_s = m_btn1; m_btn1 = bt;
      m_hold_s = m_hold1; m_hold1 = hd;
      m_edges++;
      exp_rstn  = (m_state == 2 || m_state == 3 || m_state == 4);
      exp_fetch = (m_state == 3);
      led0 = (m_state == 3) ? (((m_edges / HB) % 2) == 1) : (m_state == 4);
      check(phase, {core_rstn_o, fetch_enable_o, state_o, led_o},
            {exp_rstn, exp_fetch, 3'(m_state), m_hold_s, exp_fetch, m_lock_s, led0});
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) tick1();
   endtask

   task automatic wait_state(input int tgt, input int budget);
      int n;
      n = 0;
      while (m_state != tgt && n < budget) begin
         tick1();
         n++;
      end
      check({phase, " wait_state"}, 32'(m_state), 32'(tgt));
   endtask

   initial begin
      model_reset();
      mmcm_locked_i = 1'b1;
      #1;
      apply_reset();

      phase = "t1_boot";
      tick(3);
      check("t1_settle_entry", 32'(state_o), 32'd1);
      tick(SETTLE - 1);
      check("t1_rstn_before", 32'(core_rstn_o), 32'd0);
      tick(1);
      check("t1_rstn_rise", 32'(core_rstn_o), 32'd1);
      tick(FETCH - 1);
      check("t1_fetch_before", 32'(fetch_enable_o), 32'd0);
      tick(1);
      check("t1_fetch_rise", 32'(fetch_enable_o), 32'd1);
      check("t1_state_run", 32'(state_o), 32'd3);
      tick(25 + $urandom_range(0, 10));

      phase = "t2_bounce";
      repeat (3 + $urandom_range(0, 2)) begin
         restart_btn_i = 1'b1;
         tick($urandom_range(1, 2));
         restart_btn_i = 1'b0;
         tick($urandom_range(4, 7));
      end
      check("t2_no_restart", 32'(state_o), 32'd3);
      phase = "t2_press";
      restart_btn_i = 1'b1;
      tick(6);
      restart_btn_i = 1'b0;
      wait_state(5, 20);
      tick(RESTRT + SETTLE - 1);
      check("t2_rstn_low", 32'(core_rstn_o), 32'd0);
      tick(1);
      check("t2_rstn_high", 32'(core_rstn_o), 32'd1);
      wait_state(3, 50);

      phase = "t3_hold";
      restart_btn_i = 1'b1;
      tick(6);
      restart_btn_i = 1'b0;
      wait_state(2, 80);
      hold_fetch_i = 1'b1;
      wait_state(4, 30);
      tick($urandom_range(2, 10));
      check("t3_hold_led0", 32'(led_o[0]), 32'd1);
      check("t3_hold_fetch", 32'(fetch_enable_o), 32'd0);
      hold_fetch_i = 1'b0;
      tick(2);
      check("t3_fetch_2", 32'(fetch_enable_o), 32'd0);
      tick(1);
      check("t3_fetch_3", 32'(fetch_enable_o), 32'd1);

      phase = "t4_lockloss";
      tick($urandom_range(1, 15));
      mmcm_locked_i = 1'b0;
      tick(2);
      check("t4_rstn_2", 32'(core_rstn_o), 32'd1);
      tick(1);
      check("t4_outs_3", {29'd0, core_rstn_o, fetch_enable_o, 1'b0}, 32'd0);
      check("t4_state_lock", 32'(state_o), 32'd0);
      mmcm_locked_i = 1'b1;
      wait_state(1, 10);
      tick($urandom_range(1, 12));
      mmcm_locked_i = 1'b0;
      tick(4);
      mmcm_locked_i = 1'b1;
      wait_state(3, 60);

      phase = "t5_async";
      restart_btn_i = 1'b1;
      tick(6);
      restart_btn_i = 1'b0;
      wait_state(2, 80);
      tick($urandom_range(0, 5));
      apply_reset();
      phase = "t5_reboot";
      wait_state(3, 60);

      phase = "t6_collide";
      restart_btn_i = 1'b1;
      tick(4);
      mmcm_locked_i = 1'b0;
      tick(3);
      check("t6_lock_wins", 32'(state_o), 32'd0);
      restart_btn_i = 1'b0;
      tick(6);
      mmcm_locked_i = 1'b1;
      phase = "t6_settle_press";
      wait_state(1, 10);
      restart_btn_i = 1'b1;
      tick(8);
      restart_btn_i = 1'b0;
      tick(SETTLE - 9);
      check("t6_settle_hold", {30'd0, core_rstn_o, 1'b0}, 32'd0);
      tick(1);
      check("t6_release", 32'(state_o), 32'd2);
      wait_state(3, 30);
      tick(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
